ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one 2-way 32-bit RAM port between the instruction-fetch master (read-only: en/addr/rdata)
//  and the data master (req/we/be/addr/wdata). Grants at most one request per cycle, tracks
//  in-flight accesses in a LATENCY-deep tag pipeline, and steers rvalid/rdata/err back to the
//  issuing master. Sits between core fetch/LSU and the unified on-chip RAM.
// PARAMETERS
//  ADDR_WIDTH  32  address width of both masters and the RAM port
//  LATENCY     1   fixed RAM response latency in cycles, legal range 1..4
//  MAX_WAIT    3   consecutive lost arbitrations before fetch is forced (only with RAM_ARB_STARVE_EN)
// PORTS
//  clk         in   1           clock
//  reset       in   1           synchronous, active-high reset
//  ins_en      in   1           fetch request, held until ins_gnt
//  ins_addr    in   ADDR_WIDTH  fetch address
//  ins_gnt     out  1           fetch request accepted this cycle
//  ins_rvalid  out  1           fetch response valid
//  ins_rdata   out  32          fetch read data
//  ins_err     out  1           fetch access error
//  data_req    in   1           data request, held with all fields stable until data_gnt
//  data_we     in   1           1 = write
//  data_be     in   4           byte enables
//  data_addr   in   ADDR_WIDTH  data address
//  data_wdata  in   32          write data
//  data_gnt    out  1           data request accepted this cycle
//  data_rvalid out  1           data response valid (reads and writes)
//  data_rdata  out  32          data read data
//  data_err    out  1           data access error
//  ram_req     out  1           RAM request; the RAM accepts every cycle
//  ram_we / ram_be / ram_addr / ram_wdata  out  1/4/ADDR_WIDTH/32  RAM request fields
//  ram_rvalid / ram_rdata / ram_err        in   1/32/1             RAM response, LATENCY cycles after ram_req
// BEHAVIOUR
//  - Grant is combinational, zero added latency: ram_req = ins_en | data_req when not in reset.
//  - Default policy is fixed data priority: both requesting -> data_gnt=1, ins_gnt=0.
//  - Fetch grant drives ram_we=0, ram_be=4'hF, ram_wdata=0.
//  - Idle cycles drive ram_we/ram_be/ram_addr/ram_wdata to 0.
//  - Tag pipeline: LATENCY stages of {valid, owner}, shifted every cycle. Stage 0 is loaded
//    with the owner of the granted request, or OWNER_NONE when nothing is granted.
//  - Response routing: when ram_rvalid=1 and last stage = OWNER_INS -> ins_rvalid=1 and
//    ins_rdata/ins_err = ram_rdata/ram_err; OWNER_DATA -> the same on the data_* outputs.
//  - Un-owned rvalid (last stage OWNER_NONE) is dropped. Simulation assertion fires.
//  - Non-selected rdata outputs are 0. rvalid outputs never assert without ram_rvalid.
//  - Back-to-back grants allowed every cycle; up to LATENCY accesses in flight.
//  - Reset: all gnt/rvalid/err/rdata/ram_* outputs 0 while reset=1; tag pipeline cleared;
//    wait counter cleared.
//  - Reset mid-operation: in-flight responses arriving after reset deasserts are dropped
//    as un-owned.
//  - A write to data and a fetch response completing in the same cycle are independent.
//    The response routes by tag; the new grant goes by policy.
// CONFIGURATION
//  RAM_ARB_STARVE_EN defined:
//  - 2-bit-or-wider wait_cnt increments each cycle ins_en=1 && !ins_gnt, and clears on ins_gnt.
//  - When wait_cnt == MAX_WAIT and ins_en=1, fetch wins over data: data_gnt=0 that cycle.
//  - wait_cnt saturates at MAX_WAIT.
//  RAM_ARB_STARVE_EN undefined:
//  - No counter; pure data priority. Fetch can starve under continuous data_req.
// STRUCTURE
//  - Package ram_arb_pkg:
//    - owner_e enum {OWNER_NONE, OWNER_INS, OWNER_DATA}
//    - ram_tag_t struct {logic valid; owner_e owner}
//    - RAM_ARB_MAX_LATENCY = 4
//  - Sub-module ram_arb_tag_pipe: parameterised LATENCY-deep ram_tag_t shift register
//    with synchronous clear.
//  - Top level holds the grant logic, the optional wait counter and the response mux.
// TESTING
//  - Only data_req, read, addr 0x40, LATENCY=1 -> data_gnt same cycle; next cycle
//    data_rvalid=1, data_rdata=ram_rdata, ins_rvalid=0.
//  - ins_en and data_req both held 6 cycles, STARVE_EN off -> data_gnt 6/6, ins_gnt 0.
//    Same with STARVE_EN on, MAX_WAIT=3 -> ins_gnt in cycle 4 only.
//  - LATENCY=3, grants ins, data, ins on consecutive cycles -> responses route
//    ins, data, ins in cycles 3, 4, 5.
//  - Data write, be=4'b0011, ram_err=1 on response -> data_rvalid=1, data_err=1, ins_err=0.
//  - LATENCY=2, grant ins, assert reset the next cycle for 1 cycle; RAM still returns
//    rvalid -> ins_rvalid stays 0 throughout.
//  - ram_rvalid=1 with no prior grant -> no rvalid output, assertion flags it.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: response owner tags and the tag-pipeline entry.
package ram_arb_pkg;

  localparam int unsigned RAM_ARB_MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_INS,
    OWNER_DATA
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } ram_tag_t;

  localparam ram_tag_t TAG_NONE = '{valid: 1'b0, owner: OWNER_NONE};

endpackage

// File: rtl/ram_arb_tag_pipe.sv
// LATENCY-deep shift register of response tags; tag_out lines up with the RAM response.
module ram_arb_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic     clk,
  input  logic     clear,
  input  ram_tag_t tag_in,
  output ram_tag_t tag_out
);

  ram_tag_t stage_q [LATENCY];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[LATENCY-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between fetch and data masters; data has priority.
// Define RAM_ARB_STARVE_EN to force a fetch grant after MAX_WAIT lost arbitrations.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ins_en,
  input  logic [ADDR_WIDTH-1:0] ins_addr,
  output logic                  ins_gnt,
  output logic                  ins_rvalid,
  output logic [31:0]           ins_rdata,
  output logic                  ins_err,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [3:0]            data_be,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [31:0]           data_rdata,
  output logic                  data_err,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic                  ram_rvalid,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_err
);

  logic     force_ins;
  logic     route_ins, route_data;
  logic     unowned_rvalid;
  ram_tag_t tag_in, tag_out;

`ifdef RAM_ARB_STARVE_EN
  localparam int unsigned CntW = (MAX_WAIT < 4) ? 2 : $clog2(MAX_WAIT + 1);
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  assign force_ins = ins_en && (wait_cnt_q == CntW'(MAX_WAIT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (ins_gnt) begin
      wait_cnt_d = '0;
    end else if (ins_en && (wait_cnt_q != CntW'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  assign force_ins = 1'b0;
`endif

  assign data_gnt = !reset && data_req && !force_ins;
  assign ins_gnt  = !reset && ins_en && (!data_req || force_ins);
  assign ram_req  = data_gnt || ins_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    tag_in    = TAG_NONE;
    if (data_gnt) begin
      ram_we    = data_we;
      ram_be    = data_be;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
      tag_in    = '{valid: 1'b1, owner: OWNER_DATA};
    end else if (ins_gnt) begin
      ram_be    = 4'hF;
      ram_addr  = ins_addr;
      tag_in    = '{valid: 1'b1, owner: OWNER_INS};
    end
  end

  ram_arb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .clear   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Responses follow the tag, independent of whatever is being granted this cycle.
  assign route_ins  = !reset && ram_rvalid && tag_out.valid && (tag_out.owner == OWNER_INS);
  assign route_data = !reset && ram_rvalid && tag_out.valid && (tag_out.owner == OWNER_DATA);
  assign unowned_rvalid = !reset && ram_rvalid && !route_ins && !route_data;

  assign ins_rvalid  = route_ins;
  assign ins_rdata   = route_ins ? ram_rdata : 32'h0;
  assign ins_err     = route_ins && ram_err;
  assign data_rvalid = route_data;
  assign data_rdata  = route_data ? ram_rdata : 32'h0;
  assign data_err    = route_data && ram_err;

`ifdef RAM_ARB_CHECK_UNOWNED
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!unowned_rvalid) else $error("ram_port_arbiter: un-owned ram_rvalid dropped");
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: three arbiter instances (LATENCY 1, 2, 3) share stimulus; each test
// checks the instance whose latency it targets.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ins_en;
  logic [31:0] ins_addr;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        ram_rvalid, ram_err;
  logic [31:0] ram_rdata;

  logic        ins_gnt [3], ins_rvalid [3], ins_err [3];
  logic [31:0] ins_rdata [3];
  logic        data_gnt [3], data_rvalid [3], data_err [3];
  logic [31:0] data_rdata [3];
  logic        ram_req [3], ram_we [3];
  logic [3:0]  ram_be [3];
  logic [31:0] ram_addr [3], ram_wdata [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_port_arbiter #(
      .ADDR_WIDTH (32),
      .LATENCY    (g + 1),
      .MAX_WAIT   (3)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .ins_en      (ins_en),
      .ins_addr    (ins_addr),
      .ins_gnt     (ins_gnt[g]),
      .ins_rvalid  (ins_rvalid[g]),
      .ins_rdata   (ins_rdata[g]),
      .ins_err     (ins_err[g]),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_be     (data_be),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt[g]),
      .data_rvalid (data_rvalid[g]),
      .data_rdata  (data_rdata[g]),
      .data_err    (data_err[g]),
      .ram_req     (ram_req[g]),
      .ram_we      (ram_we[g]),
      .ram_be      (ram_be[g]),
      .ram_addr    (ram_addr[g]),
      .ram_wdata   (ram_wdata[g]),
      .ram_rvalid  (ram_rvalid),
      .ram_rdata   (ram_rdata),
      .ram_err     (ram_err)
    );
  end

  task automatic idle_inputs();
    ins_en = 0; ins_addr = 0; data_req = 0; data_we = 0; data_be = 0;
    data_addr = 0; data_wdata = 0; ram_rvalid = 0; ram_rdata = 0; ram_err = 0;
  endtask

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; ins_en = 1; data_req = 1; data_we = 1; data_be = 4'hF;
    data_addr = 32'h44; data_wdata = 32'h1234_5678; ram_rvalid = 1; ram_rdata = 32'hFFFF_FFFF;
    ram_err = 1;
    next_cycle();
    #1;
    checks++;
    if ({data_gnt[0], ins_gnt[0], ram_req[0], ram_we[0]} !== 4'b0) begin
      failures++;
      $display("FAIL reset_gnt got=%b exp=0000", {data_gnt[0], ins_gnt[0], ram_req[0], ram_we[0]});
    end
    checks++;
    if ({ram_be[0], ram_addr[0], ram_wdata[0]} !== 68'h0) begin
      failures++;
      $display("FAIL reset_ram_fields got=%h exp=0", {ram_be[0], ram_addr[0], ram_wdata[0]});
    end
    checks++;
    if ({ins_rvalid[0], data_rvalid[0], ins_err[0], data_err[0], data_rdata[0]} !== 36'h0) begin
      failures++;
      $display("FAIL reset_resp got=%h exp=0",
               {ins_rvalid[0], data_rvalid[0], ins_err[0], data_err[0], data_rdata[0]});
    end
    apply_reset();
  endtask

  task automatic test_idle_and_fetch_fields();
    data_wdata = 32'hA5A5_A5A5; data_be = 4'h3; data_addr = 32'h80;
    #1;
    checks++;
    if ({ram_req[0], ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0]} !== 70'h0) begin
      failures++;
      $display("FAIL idle_fields got=%h exp=0",
               {ram_req[0], ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0]});
    end
    ins_en = 1; ins_addr = 32'h100;
    #1;
    checks++;
    if ({ins_gnt[0], data_gnt[0], ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0]}
        !== {1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0}) begin
      failures++;
      $display("FAIL fetch_fields got=%h exp=%h",
               {ins_gnt[0], data_gnt[0], ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0]},
               {1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0});
    end
    apply_reset();
  endtask

  task automatic test_data_read();
    data_req = 1; data_addr = 32'h40;
    #1;
    checks++;
    if ({data_gnt[0], ins_gnt[0], ram_req[0], ram_addr[0]} !== {3'b101, 32'h40}) begin
      failures++;
      $display("FAIL read_gnt got=%h exp=%h", {data_gnt[0], ins_gnt[0], ram_req[0], ram_addr[0]},
               {3'b101, 32'h40});
    end
    next_cycle();
    data_req = 0; ram_rvalid = 1; ram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({data_rvalid[0], data_rdata[0], ins_rvalid[0], ins_rdata[0]}
        !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL read_resp got=%h exp=%h",
               {data_rvalid[0], data_rdata[0], ins_rvalid[0], ins_rdata[0]},
               {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0});
    end
    apply_reset();
  endtask

  task automatic test_priority();
    logic exp_ins;
    ins_en = 1; ins_addr = 32'h200; data_req = 1; data_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_STARVE_EN
      exp_ins = (i == 3);
`else
      exp_ins = 1'b0;
`endif
      #1;
      checks++;
      if ({ins_gnt[0], data_gnt[0]} !== {exp_ins, !exp_ins}) begin
        failures++;
        $display("FAIL priority_cycle%0d got=%b exp=%b", i + 1, {ins_gnt[0], data_gnt[0]},
                 {exp_ins, !exp_ins});
      end
      next_cycle();
    end
    apply_reset();
  endtask

  task automatic test_latency3_routing();
    ins_en = 1; ins_addr = 32'h10;
    #1;
    checks++;
    if (ins_gnt[2] !== 1'b1) begin
      failures++; $display("FAIL l3_gnt0 got=%b exp=1", ins_gnt[2]);
    end
    next_cycle();
    ins_en = 0; data_req = 1; data_addr = 32'h20;
    #1;
    checks++;
    if (data_gnt[2] !== 1'b1) begin
      failures++; $display("FAIL l3_gnt1 got=%b exp=1", data_gnt[2]);
    end
    next_cycle();
    data_req = 0; ins_en = 1; ins_addr = 32'h30;
    next_cycle();
    ins_en = 0; ram_rvalid = 1; ram_rdata = 32'hA1;
    #1;
    checks++;
    if ({ins_rvalid[2], ins_rdata[2], data_rvalid[2]} !== {1'b1, 32'hA1, 1'b0}) begin
      failures++;
      $display("FAIL l3_resp3 got=%h exp=%h", {ins_rvalid[2], ins_rdata[2], data_rvalid[2]},
               {1'b1, 32'hA1, 1'b0});
    end
    next_cycle();
    ram_rdata = 32'hB2;
    #1;
    checks++;
    if ({data_rvalid[2], data_rdata[2], ins_rvalid[2]} !== {1'b1, 32'hB2, 1'b0}) begin
      failures++;
      $display("FAIL l3_resp4 got=%h exp=%h", {data_rvalid[2], data_rdata[2], ins_rvalid[2]},
               {1'b1, 32'hB2, 1'b0});
    end
    next_cycle();
    ram_rdata = 32'hC3;
    #1;
    checks++;
    if ({ins_rvalid[2], ins_rdata[2], data_rvalid[2]} !== {1'b1, 32'hC3, 1'b0}) begin
      failures++;
      $display("FAIL l3_resp5 got=%h exp=%h", {ins_rvalid[2], ins_rdata[2], data_rvalid[2]},
               {1'b1, 32'hC3, 1'b0});
    end
    apply_reset();
  endtask

  task automatic test_write_err();
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h84; data_wdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0]}
        !== {1'b1, 4'b0011, 32'h84, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL write_fields got=%h exp=%h", {ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0]},
               {1'b1, 4'b0011, 32'h84, 32'hCAFE_F00D});
    end
    next_cycle();
    data_req = 0; ram_rvalid = 1; ram_err = 1; ram_rdata = 32'h0;
    #1;
    checks++;
    if ({data_rvalid[0], data_err[0], ins_rvalid[0], ins_err[0]} !== 4'b1100) begin
      failures++;
      $display("FAIL write_err got=%b exp=1100",
               {data_rvalid[0], data_err[0], ins_rvalid[0], ins_err[0]});
    end
    apply_reset();
  endtask

  // Fetch response and a new data write grant land in the same cycle.
  task automatic test_back_to_back();
    ins_en = 1; ins_addr = 32'h400;
    next_cycle();
    ins_en = 0; data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h500;
    ram_rvalid = 1; ram_rdata = 32'h1111_2222;
    #1;
    checks++;
    if ({data_gnt[0], ins_rvalid[0], ins_rdata[0], data_rvalid[0]}
        !== {1'b1, 1'b1, 32'h1111_2222, 1'b0}) begin
      failures++;
      $display("FAIL b2b_overlap got=%h exp=%h",
               {data_gnt[0], ins_rvalid[0], ins_rdata[0], data_rvalid[0]},
               {1'b1, 1'b1, 32'h1111_2222, 1'b0});
    end
    next_cycle();
    data_req = 0; ram_rdata = 32'h0;
    #1;
    checks++;
    if ({data_rvalid[0], ins_rvalid[0]} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_write_resp got=%b exp=10", {data_rvalid[0], ins_rvalid[0]});
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_flight();
    ins_en = 1; ins_addr = 32'h600;
    #1;
    checks++;
    if (ins_gnt[1] !== 1'b1) begin
      failures++; $display("FAIL midreset_gnt got=%b exp=1", ins_gnt[1]);
    end
    next_cycle();
    ins_en = 0; reset = 1;
    #1;
    checks++;
    if ({ins_rvalid[1], ram_req[1]} !== 2'b00) begin
      failures++; $display("FAIL midreset_during got=%b exp=00", {ins_rvalid[1], ram_req[1]});
    end
    next_cycle();
    reset = 0; ram_rvalid = 1; ram_rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if ({ins_rvalid[1], ins_rdata[1], data_rvalid[1], g_dut[1].u_dut.unowned_rvalid}
        !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_drop got=%h exp=%h",
               {ins_rvalid[1], ins_rdata[1], data_rvalid[1], g_dut[1].u_dut.unowned_rvalid},
               {1'b0, 32'h0, 1'b0, 1'b1});
    end
    apply_reset();
  endtask

  task automatic test_unowned();
    ram_rvalid = 1; ram_rdata = 32'h7777_7777; ram_err = 1;
    #1;
    checks++;
    if ({ins_rvalid[0], data_rvalid[0], ins_err[0], data_err[0], g_dut[0].u_dut.unowned_rvalid}
        !== 5'b00001) begin
      failures++;
      $display("FAIL unowned got=%b exp=00001",
               {ins_rvalid[0], data_rvalid[0], ins_err[0], data_err[0],
                g_dut[0].u_dut.unowned_rvalid});
    end
    apply_reset();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    next_cycle();
    test_reset();
    test_idle_and_fetch_fields();
    test_data_read();
    test_priority();
    test_latency3_routing();
    test_write_err();
    test_back_to_back();
    test_reset_mid_flight();
    test_unowned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
